// File: rtl/riscv_pkg.sv
// riscv_pkg
//   Shared definitions for the front end of the pipeline: canonical NOP and
//   EBREAK encodings, the fetch-state enum, and an alignment helper. Decode
//   imports the same package so both stages agree on the NOP used for flushes.
package riscv_pkg;

  localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;  // addi x0, x0, 0
  localparam logic [31:0] EBREAK_INSTR = 32'h0010_0073;

  typedef enum logic [1:0] {
    FETCH_BOOT = 2'd0,
    FETCH_RUN  = 2'd1,
    FETCH_HALT = 2'd2
  } fetch_state_t;

  function automatic logic is_word_aligned(input logic [31:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// instruction_fetch_if
//   Bundles the fetch stage's memory, control and IF/ID signals.
//   master : the fetch unit (drives pc, IF/ID fields and status)
//   slave  : the surrounding core / memory (drives instruction, stall,
//            redirect request)
interface instruction_fetch_if;

  logic [31:0] pc;
  logic [31:0] instruction;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_id_valid;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_instr;
  logic        halted;
  logic        fault;
  logic [31:0] fetch_count;

  modport master (
    input  instruction, stall, redirect_valid, redirect_pc,
    output pc, if_id_valid, if_id_pc, if_id_instr, halted, fault, fetch_count
  );

  modport slave (
    output instruction, stall, redirect_valid, redirect_pc,
    input  pc, if_id_valid, if_id_pc, if_id_instr, halted, fault, fetch_count
  );

endinterface

// File: rtl/if_id_reg.sv
// if_id_reg
//   IF/ID pipeline register.
//   clk, rst        : clock, async active-high reset
//   load            : capture pc_in/instr_in and mark valid
//   flush           : replace contents with an invalid NOP at pc 0 (wins over load)
//   pc_in, instr_in : fetched address and instruction word
//   valid, pc, instr: registered outputs
module if_id_reg
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        flush,
  input  logic [31:0] pc_in,
  input  logic [31:0] instr_in,
  output logic        valid,
  output logic [31:0] pc,
  output logic [31:0] instr
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      pc    <= 32'h0;
      instr <= NOP_INSTR;
    end else if (flush) begin
      valid <= 1'b0;
      pc    <= 32'h0;
      instr <= NOP_INSTR;
    end else if (load) begin
      valid <= 1'b1;
      pc    <= pc_in;
      instr <= instr_in;
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch
//   Fetch stage: owns the PC, feeds the IF/ID register, and sequences
//   BOOT -> RUN -> HALT around EBREAK and misaligned redirects.
//   clk   : rising-edge clock
//   reset : asynchronous, active-high
//   bus   : instruction_fetch_if.master (pc out, instruction in, stall and
//           redirect in, IF/ID fields, halted, fault, fetch_count out)
//
//   state | meaning
//   BOOT  | first cycle after reset release, nothing captured
//   RUN   | fetching sequentially, one word per unstalled edge
//   HALT  | stopped after EBREAK or misaligned redirect; waits for a redirect
module instruction_fetch
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                reset,
  instruction_fetch_if.master bus
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         fault_q, fault_d;
  logic [31:0]  count_q;
  logic         load, flush;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= FETCH_BOOT;
      pc_q    <= RESET_PC;
      fault_q <= 1'b0;
      count_q <= 32'h0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      fault_q <= fault_d;
      if (load) count_q <= count_q + 32'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    fault_d = fault_q;
    load    = 1'b0;
    flush   = 1'b0;
    if (bus.redirect_valid) begin
      // Redirect beats stall and EBREAK; a misaligned target is still
      // loaded (low bits dropped) so the offending address is visible.
      flush = 1'b1;
      pc_d  = {bus.redirect_pc[31:2], 2'b00};
      if (is_word_aligned(bus.redirect_pc)) begin
        state_d = FETCH_RUN;
      end else begin
        fault_d = 1'b1;
        state_d = FETCH_HALT;
      end
    end else begin
      case (state_q)
        // BOOT is a fixed one-cycle window, independent of stall.
        FETCH_BOOT: state_d = FETCH_RUN;
        FETCH_RUN: begin
          if (!bus.stall) begin
            load = 1'b1;
            if (bus.instruction == EBREAK_INSTR) begin
              state_d = FETCH_HALT;
            end else begin
              pc_d = pc_q + 32'd4;
            end
          end
        end
        FETCH_HALT: begin
          if (!bus.stall) flush = 1'b1;
        end
        default: state_d = FETCH_BOOT;
      endcase
    end
  end

  if_id_reg u_if_id_reg (
    .clk      (clk),
    .rst      (reset),
    .load     (load),
    .flush    (flush),
    .pc_in    (pc_q),
    .instr_in (bus.instruction),
    .valid    (bus.if_id_valid),
    .pc       (bus.if_id_pc),
    .instr    (bus.if_id_instr)
  );

  assign bus.pc          = pc_q;
  assign bus.halted      = (state_q == FETCH_HALT);
  assign bus.fault       = fault_q;
  assign bus.fetch_count = count_q;

endmodule
